alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
//  Parametrised ALU: single-cycle logic/arith/shift ops plus iterative multiply
//  (shift-add) and unsigned divide/remainder (restoring). Valid/ready handshake on
//  both sides; one operation in flight. Drop-in compute unit for the multicycle
//  datapath and the next generation of the single-cycle combinational alu.
// PARAMETERS
//  WIDTH    32               operand/result width; power of two, >= 8
//  SHAMT_W  $clog2(WIDTH)    shift-amount width (derived; do not override)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      operands/op presented
//  in_ready   out  1      ALU can accept (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (shifts use b[SHAMT_W-1:0])
//  alu_op     in   4      operation code (table below)
//  out_valid  out  1      result/flags valid, held until out_ready
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  result
//  zero       out  1      result == 0
//  div_zero   out  1      DIVU/REMU with b == 0
//  illegal    out  1      unsupported alu_op
// BEHAVIOUR
//  Ops: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SLL, 0110 SUB,
//   0111 SLT (signed, result 0/1), 1000 SLTU, 1001 SRL, 1010 SRA, 1100 MUL (low
//   WIDTH bits of product), 1101 DIVU, 1110 REMU; 1011, 1111 illegal.
//  ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
//  Accept = in_valid & in_ready; a, b, alu_op are captured on the accepting edge.
//  FSM IDLE -> (accept, single-cycle op or illegal) DONE;
//   IDLE -> (accept, MUL/DIVU/REMU) BUSY; BUSY -> DONE after WIDTH iterations;
//   DONE -> (out_ready) IDLE; DONE with out_ready low: stay, outputs stable.
//  Latency, counted from the accept edge: single-cycle/illegal ops give
//   out_valid on the next edge (1); MUL/DIVU/REMU give out_valid after WIDTH+1 edges.
//   out_valid is a registered output.
//  in_ready = (state == IDLE); no accept in the same cycle as the DONE->IDLE handoff.
//  Iteration counter runs 0..WIDTH-1; BUSY exits when the counter reaches WIDTH-1.
//  DIVU with b=0: result all-ones, div_zero=1. REMU with b=0: result=a, div_zero=1.
//   Latency is unchanged (still WIDTH+1).
//  Illegal op: result 0, zero 1, illegal 1, latency 1.
//  zero, div_zero and illegal are registered with result; all are valid only
//   while out_valid=1.
//  Reset (any state, including mid-BUSY): next state IDLE; out_valid, result,
//   zero, div_zero, illegal and the counter all become 0; in_ready=1 on the
//   following cycle. Any in-flight operation is discarded.
//  in_valid while not in IDLE is ignored; no input value is sampled.
// TESTING (WIDTH=32)
//  ADD 7FFFFFFF+00000001 -> 80000000, zero=0, out_valid 1 edge after accept;
//   SUB 5-5 -> 0, zero=1
//  SRA 80000000 by b=0x24 (shamt 4) -> F8000000; SLT FFFFFFFF,1 -> 1;
//   SLTU FFFFFFFF,1 -> 0; op 1011 -> illegal=1, result 0
//  MUL 00010003*00000005 -> 0005000F; out_valid exactly 33 edges after accept;
//   in_ready=0 throughout
//  DIVU 100/7 -> 14, REMU 100/7 -> 2; DIVU x/0 -> FFFFFFFF, div_zero=1;
//   REMU 9/0 -> 9, div_zero=1
//  Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and flags
//   stable, in_ready=0; out_ready=1 -> IDLE on the next edge
//  Reset pulse on the 10th cycle of a MUL -> next edge: IDLE, out_valid=0,
//   in_ready=1; a following ADD 2+3 -> 5 with correct latency

Source files
------------

// File: rtl/alu_multicycle.sv
// Parametrised ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring unsigned divide/remainder.
// Valid/ready on both sides, one operation in flight.
module alu_multicycle #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [3:0]         alu_op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               zero,
   output logic               div_zero,
   output logic               illegal
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_MUL  = 4'b1100;
   localparam logic [3:0] OP_DIVU = 4'b1101;
   localparam logic [3:0] OP_REMU = 4'b1110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [SHAMT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]           op_q, op_d;
   logic [WIDTH-1:0]     opa_q, opa_d;     // multiplicand (MUL) / dividend->quotient (DIV)
   logic [WIDTH-1:0]     opb_q, opb_d;     // multiplier (MUL) / divisor (DIV)
   logic [WIDTH-1:0]     acc_q, acc_d;     // product accumulator (MUL) / remainder (DIV)
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 zero_q, zero_d;
   logic                 div_zero_q, div_zero_d;
   logic                 illegal_q, illegal_d;
   logic                 out_valid_q, out_valid_d;

   logic [WIDTH-1:0]     alu_res_c;
   logic                 alu_ill_c;
   logic                 is_iter_c;
   logic [SHAMT_W-1:0]   shamt_c;

   logic [WIDTH-1:0]     mul_acc_c;
   logic [WIDTH:0]       rem_sh_c;
   logic [WIDTH:0]       rem_diff_c;
   logic [WIDTH-1:0]     rem_new_c;
   logic [WIDTH-1:0]     quo_new_c;

   assign shamt_c = b[SHAMT_W-1:0];
   assign is_iter_c = (alu_op == OP_MUL) || (alu_op == OP_DIVU) || (alu_op == OP_REMU);

   // Single-cycle operation result, taken straight from the input operands
   always_comb begin
      alu_res_c = '0;
      alu_ill_c = 1'b0;
      unique case (alu_op)
         OP_AND:  alu_res_c = a & b;
         OP_OR:   alu_res_c = a | b;
         OP_ADD:  alu_res_c = a + b;
         OP_XOR:  alu_res_c = a ^ b;
         OP_NOR:  alu_res_c = ~(a | b);
         OP_SLL:  alu_res_c = a << shamt_c;
         OP_SUB:  alu_res_c = a - b;
         OP_SLT:  alu_res_c = WIDTH'($signed(a) < $signed(b));
         OP_SLTU: alu_res_c = WIDTH'(a < b);
         OP_SRL:  alu_res_c = a >> shamt_c;
         OP_SRA:  alu_res_c = WIDTH'($signed(a) >>> shamt_c);
         OP_MUL, OP_DIVU, OP_REMU: alu_res_c = '0;
         default: alu_ill_c = 1'b1;
      endcase
   end

   // One iteration step of the shift-add multiplier and the restoring divider
   always_comb begin
      mul_acc_c  = acc_q + (opb_q[0] ? opa_q : '0);
      rem_sh_c   = {acc_q, opa_q[WIDTH-1]};
      rem_diff_c = rem_sh_c - {1'b0, opb_q};
      // A divisor of zero never borrows, so the quotient fills with ones
      // and the remainder ends up as the dividend, as required.
      rem_new_c  = rem_diff_c[WIDTH] ? rem_sh_c[WIDTH-1:0] : rem_diff_c[WIDTH-1:0];
      quo_new_c  = {opa_q[WIDTH-2:0], ~rem_diff_c[WIDTH]};
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      acc_d       = acc_q;
      result_d    = result_q;
      zero_d      = zero_q;
      div_zero_d  = div_zero_q;
      illegal_d   = illegal_q;
      out_valid_d = out_valid_q;

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (is_iter_c) begin
                  state_d = S_BUSY;
                  cnt_d   = '0;
                  op_d    = alu_op;
                  opa_d   = a;
                  opb_d   = b;
                  acc_d   = '0;
               end else begin
                  state_d     = S_DONE;
                  result_d    = alu_res_c;
                  zero_d      = (alu_res_c == '0);
                  div_zero_d  = 1'b0;
                  illegal_d   = alu_ill_c;
                  out_valid_d = 1'b1;
               end
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (op_q == OP_MUL) begin
               acc_d = mul_acc_c;
               opa_d = opa_q << 1;
               opb_d = opb_q >> 1;
            end else begin
               acc_d = rem_new_c;
               opa_d = quo_new_c;
            end
            if (cnt_q == SHAMT_W'(WIDTH - 1)) begin
               state_d     = S_DONE;
               out_valid_d = 1'b1;
               illegal_d   = 1'b0;
               unique case (op_q)
                  OP_MUL:  result_d = mul_acc_c;
                  OP_DIVU: result_d = quo_new_c;
                  default: result_d = rem_new_c;
               endcase
               zero_d     = (result_d == '0);
               div_zero_d = (op_q != OP_MUL) && (opb_q == '0);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         acc_q       <= '0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         div_zero_q  <= 1'b0;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         acc_q       <= acc_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         div_zero_q  <= div_zero_d;
         illegal_q   <= illegal_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign div_zero  = div_zero_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed cases with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_alu_multicycle;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [3:0]    alu_op;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic          zero;
   logic          div_zero;
   logic          illegal;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_multicycle #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .alu_op    (alu_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .div_zero  (div_zero),
      .illegal   (illegal)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: what an operation must produce, from plain arithmetic
   function automatic void model_calc(input logic [3:0] op, input logic [W-1:0] x,
                                      input logic [W-1:0] y, output logic [W-1:0] r,
                                      output logic dz, output logic il);
      logic [63:0] p;
      int sh;
      sh = int'(y[4:0]);
      dz = 1'b0;
      il = 1'b0;
      r  = '0;
      case (op)
         4'd0:  r = x & y;
         4'd1:  r = x | y;
         4'd2:  r = x + y;
         4'd3:  r = x ^ y;
         4'd4:  r = ~(x | y);
         4'd5:  r = x << sh;
         4'd6:  r = x - y;
         4'd7:  r = (int'(x) < int'(y)) ? 32'd1 : 32'd0;
         4'd8:  r = (x < y) ? 32'd1 : 32'd0;
         4'd9:  r = x >> sh;
         4'd10: r = W'($signed(x) >>> sh);
         4'd12: begin p = 64'(x) * 64'(y); r = p[W-1:0]; end
         4'd13: if (y == 0) begin r = '1; dz = 1'b1; end else r = x / y;
         4'd14: if (y == 0) begin r = x;  dz = 1'b1; end else r = x % y;
         default: il = 1'b1;
      endcase
   endfunction

   // Transaction-level model: one op in flight, fixed latency per op class
   bit           m_on = 1'b0;
   bit           m_valid = 1'b0;
   int           m_left = 0;
   logic [W-1:0] m_res;
   logic         m_dz;
   logic         m_il;

   always @(posedge clk) begin
      if (reset) begin
         m_on    = 1'b1;
         m_valid = 1'b0;
         m_left  = 0;
      end else if (m_on) begin
         if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_valid = 1'b1;
         end else if (in_valid) begin
            model_calc(alu_op, a, b, m_res, m_dz, m_il);
            if (alu_op == 4'd12 || alu_op == 4'd13 || alu_op == 4'd14) m_left = W;
            else m_valid = 1'b1;
         end
      end
   end

   // Cycle-by-cycle comparison of the DUT against the model
   always @(negedge clk) begin
      if (m_on && !reset) begin
         chk("out_valid", out_valid, m_valid);
         chk("in_ready", in_ready, (!m_valid && m_left == 0));
         if (m_valid) begin
            chk("result", result, m_res);
            chk("zero", zero, (m_res == '0));
            chk("div_zero", div_zero, m_dz);
            chk("illegal", illegal, m_il);
         end
      end
   end

   // Directed op with literal expectations, latency and backpressure hold
   task automatic do_op(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [3:0] iop, input logic [W-1:0] er, input logic ez,
                        input logic edz, input logic eil, input int elat, input int hold);
      int guard;
      int lat;
      logic [W-1:0] r0;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      chk({nm, "_ready_wait"}, in_ready, 1'b1);
      a = ia; b = ib; alu_op = iop; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom;
      lat = 1;
      while (!out_valid && lat < 100) begin
         chk({nm, "_busy_in_ready"}, in_ready, 1'b0);
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, "_latency"}, lat, elat);
      chk({nm, "_result"}, result, er);
      chk({nm, "_zero"}, zero, ez);
      chk({nm, "_div_zero"}, div_zero, edz);
      chk({nm, "_illegal"}, illegal, eil);
      r0 = result;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({nm, "_hold_valid"}, out_valid, 1'b1);
         chk({nm, "_hold_result"}, result, r0);
         chk({nm, "_hold_in_ready"}, in_ready, 1'b0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, "_handoff_idle"}, in_ready, 1'b1);
      chk({nm, "_handoff_valid"}, out_valid, 1'b0);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3, 4:    return W'($urandom_range(0, 300));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; alu_op = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_result", result, 32'h0);

      do_op("add_wrap", 32'h7FFF_FFFF, 32'h1, 4'b0010, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1, 0);
      do_op("sub_zero", 32'd5, 32'd5, 4'b0110, 32'h0, 1'b1, 1'b0, 1'b0, 1, 0);
      do_op("sra", 32'h8000_0000, 32'h24, 4'b1010, 32'hF800_0000, 1'b0, 1'b0, 1'b0, 1, 0);
      do_op("slt", 32'hFFFF_FFFF, 32'h1, 4'b0111, 32'h1, 1'b0, 1'b0, 1'b0, 1, 0);
      do_op("sltu", 32'hFFFF_FFFF, 32'h1, 4'b1000, 32'h0, 1'b1, 1'b0, 1'b0, 1, 0);
      do_op("illegal", 32'h1234, 32'h5678, 4'b1011, 32'h0, 1'b1, 1'b0, 1'b1, 1, 0);
      do_op("mul", 32'h0001_0003, 32'h5, 4'b1100, 32'h0005_000F, 1'b0, 1'b0, 1'b0, 33, 0);
      do_op("divu", 32'd100, 32'd7, 4'b1101, 32'd14, 1'b0, 1'b0, 1'b0, 33, 0);
      do_op("remu", 32'd100, 32'd7, 4'b1110, 32'd2, 1'b0, 1'b0, 1'b0, 33, 0);
      do_op("divu_z", 32'hDEAD_BEEF, 32'd0, 4'b1101, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 33, 0);
      do_op("remu_z", 32'd9, 32'd0, 4'b1110, 32'd9, 1'b0, 1'b1, 1'b0, 33, 0);
      do_op("bp_xor", 32'hF0F0_1234, 32'h0F0F_1234, 4'b0011, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0, 1, 5);

      // Reset pulse on the 10th cycle of a multiply
      a = 32'h1234_5678; b = 32'h9; alu_op = 4'b1100; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midmul_rst_in_ready", in_ready, 1'b1);
      chk("midmul_rst_out_valid", out_valid, 1'b0);
      chk("midmul_rst_result", result, 32'h0);
      chk("midmul_rst_div_zero", div_zero, 1'b0);
      do_op("add_after_rst", 32'd2, 32'd3, 4'b0010, 32'd5, 1'b0, 1'b0, 1'b0, 1, 0);

      // Randomized traffic, checked against the model every cycle
      for (int c = 0; c < 8000; c++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 9) < 6);
         out_ready = ($urandom_range(0, 9) < 5);
         alu_op    = 4'($urandom_range(0, 15));
         a         = pick();
         b         = pick();
         reset     = ($urandom_range(0, 999) == 0);
      end
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0;
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
